rvc_fetch_unit: RTL



---
 rtl/rvc_fetch_unit.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/rvc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the RVC cache with a halfword
// address and buffers fetched instructions with their PCs for decode.
module rvc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ic_read,
    output logic [30:0] ic_addr,
    input  logic [31:0] ic_rdata,
    input  logic        ic_stall,
    input  logic        ic_pcadd,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_is_rvc
);

    localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FQ_DEPTH);

    typedef enum logic [1:0] {FETCH, MISS, KILL} state_t;

    state_t        state, state_nx;
    logic [31:0]   pc, pc_nx, pc_inc, tgt;
    logic [31:0]   redir_r, redir_nx;
    logic [31:0]   q_instr [FQ_DEPTH];
    logic [31:0]   q_pc    [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] q_rvc;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, push, pop, flush;

    assign tgt    = br_target & ~32'h1;
    assign pc_inc = pc + (ic_pcadd ? 32'd4 : 32'd2);
    assign full   = (count == FULL_CNT);
    assign pop    = if_valid && id_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc      <= RESET_PC & ~32'h1;
            redir_r <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            redir_r <= redir_nx;
        end
    end

    // A redirect that arrives while a miss is outstanding is parked in redir_r;
    // the PC (and thus ic_addr) must not move until the cache releases the stall.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        redir_nx = redir_r;
        push     = 1'b0;
        flush    = 1'b0;
        unique case (state)
            FETCH: begin
                if (br_taken) begin
                    flush = 1'b1;
                    if (ic_stall) begin
                        redir_nx = tgt;
                        state_nx = KILL;
                    end else begin
                        pc_nx = tgt;
                    end
                end else if (ic_stall) begin
                    state_nx = MISS;
                end else if (!full) begin
                    push  = 1'b1;
                    pc_nx = pc_inc;
                end
            end
            MISS: begin
                if (br_taken) begin
                    flush    = 1'b1;
                    redir_nx = tgt;
                    state_nx = KILL;
                end else if (!ic_stall) begin
                    state_nx = FETCH;
                    if (!full) begin
                        push  = 1'b1;
                        pc_nx = pc_inc;
                    end
                end
            end
            KILL: begin
                if (br_taken) begin
                    flush    = 1'b1;
                    redir_nx = tgt;
                end
                if (!ic_stall) begin
                    pc_nx    = br_taken ? tgt : redir_r;
                    state_nx = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_comb begin
        ic_read = (state != FETCH) || (count < FULL_CNT);
        ic_addr = pc[31:1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_rvc  <= '0;
            for (int unsigned i = 0; i < FQ_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= ic_rdata;
                q_pc[wr_ptr]    <= pc;
                q_rvc[wr_ptr]   <= ~ic_pcadd;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign if_valid  = (count != '0);
    assign if_instr  = q_instr[rd_ptr];
    assign if_pc     = q_pc[rd_ptr];
    assign if_is_rvc = q_rvc[rd_ptr];

endmodule
